// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack handshake that carries one word into another clock domain.
// The ack is synchronized, each wait state has a timeout that aborts with a sticky error flag.
module cdc_handshake_tx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    input  logic              tx_ack,
    output logic              busy,
    input  logic              err_clr,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   req_q, req_d;
    logic                   err_q, err_d;
    logic                   ack_s;
    logic                   cnt_hit;

    // tx_ack is only ever observed through this chain.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], tx_ack};
    assign ack_s  = sync_q[SYNC_STAGES-1];

    assign cnt_hit     = (cnt_q == CNT_MAX);
    assign in_ready    = (state_q == IDLE) && !ack_s;
    assign busy        = (state_q != IDLE);
    assign tx_data     = data_q;
    assign tx_req      = req_q;
    assign timeout_err = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        req_d   = req_q;
        err_d   = err_q;
        // A timeout set below overrides a simultaneous clear.
        if (err_clr) begin
            err_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = REQ_LO;
                end else if (cnt_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ_LO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_hit) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                req_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync_q  <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: accepted words go to a scoreboard and are checked on each tx_req rise;
// handshake latencies, timeouts, error flag and reset behaviour are checked cycle by cycle.
module tb_cdc_handshake_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] tx_data;
    logic        tx_req;
    logic        tx_ack;
    logic        busy;
    logic        err_clr = 1'b0;
    logic        timeout_err;

    logic        echo = 1'b0;
    logic        ack_man = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    int          rise_q[$];
    logic        req_prev = 1'b0;

    always #5 clk = ~clk;

    always_comb tx_ack = echo ? tx_req : ack_man;

    cdc_handshake_tx #(.DATA_W(16), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack), .busy(busy),
        .err_clr(err_clr), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, then lets one edge accept the word; in_valid optionally stays high.
    task automatic send(input logic [15:0] w, input bit keep);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("send_wait", 32'd0, 32'd1);
        else exp_q.push_back(w);
        tick();
        if (!keep) in_valid = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_req && !req_prev) begin
            rise_q.push_back(cyc);
            if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else chk("sb_data", {16'd0, tx_data}, {16'd0, exp_q.pop_front()});
        end
        req_prev = tx_req;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // reset state and accept on the first edge after release
        in_valid = 1'b1;
        in_data  = 16'hA5C3;
        #1;
        chk("rst_req", tx_req, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(16'hA5C3);
        rst = 1'b0;
        chk("ready_first", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("acc_data", tx_data, 16'hA5C3);
        chk("acc_req", tx_req, 1);

        // ack rises one cycle after req: req falls 3 edges later, busy drops 3 edges after ack falls
        tick();
        ack_man = 1'b1;
        repeat (2) tick();
        chk("req_hold_2", tx_req, 1);
        tick();
        chk("req_fall_3", tx_req, 0);
        chk("data_hold_lo", tx_data, 16'hA5C3);
        tick();
        ack_man = 1'b0;
        repeat (2) tick();
        chk("busy_hold_2", busy, 1);
        tick();
        chk("busy_drop_3", busy, 0);
        chk("data_hold_end", tx_data, 16'hA5C3);

        // back-to-back words with an echoing ack
        echo = 1'b1;
        rise_q.delete();
        send(16'd1, 1'b1);
        send(16'd2, 1'b1);
        send(16'd3, 1'b0);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("b2b_idle", busy, 0);
        chk("b2b_count", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("b2b_gap1", rise_q[1] - rise_q[0], 7);
            chk("b2b_gap2", rise_q[2] - rise_q[1], 7);
        end
        echo = 1'b0;

        // REQ_HI timeout with ack held low
        send(16'h0BAD, 1'b0);
        repeat (8) tick();
        chk("to_req_hold", tx_req, 1);
        chk("to_err_pre", timeout_err, 0);
        tick();
        chk("to_req_fall", tx_req, 0);
        chk("to_err_set", timeout_err, 1);
        chk("to_busy_lo", busy, 1);
        tick();
        chk("to_idle", busy, 0);

        // err_clr alone, then coinciding with a timeout, then alone again
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_first", timeout_err, 0);
        send(16'h1234, 1'b0);
        repeat (8) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_vs_to", timeout_err, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_alone", timeout_err, 0);

        // ack arrives on the timeout edge: ack wins, then REQ_LO times out with ack stuck high
        send(16'h5A5A, 1'b0);
        repeat (6) tick();
        ack_man = 1'b1;
        repeat (2) tick();
        chk("race_req_hold", tx_req, 1);
        tick();
        chk("race_req_fall", tx_req, 0);
        chk("race_no_err", timeout_err, 0);
        repeat (8) tick();
        chk("lo_busy_hold", busy, 1);
        chk("lo_err_pre", timeout_err, 0);
        tick();
        chk("lo_idle", busy, 0);
        chk("lo_err_set", timeout_err, 1);
        chk("lo_ready_ack", in_ready, 0);
        ack_man = 1'b0;
        tick();
        chk("lo_ready_sync", in_ready, 0);
        tick();
        chk("lo_ready_back", in_ready, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // asynchronous reset in the middle of REQ_HI
        send(16'hC0DE, 1'b0);
        tick();
        ack_man = 1'b1;
        tick();
        chk("pre_rst_req", tx_req, 1);
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        #1;
        chk("arst_req", tx_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", tx_data, 0);
        tick();
        chk("arst_no_acc", tx_req, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        chk("post_rst_ready", in_ready, 1);
        repeat (2) tick();
        chk("post_rst_ack", in_ready, 0);
        ack_man = 1'b0;
        tick();
        chk("post_rst_sync", in_ready, 0);
        tick();
        chk("post_rst_back", in_ready, 1);

        chk("sb_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
